// File: rtl/rom_reader.sv
// Streams a burst of words out of a 1-cycle-latency synchronous ROM onto a
// valid/ready port, one ROM access per word (ADDR -> LATCH -> SEND).
module rom_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DEPTH_LOG-1:0] start_addr,
    input  logic [DEPTH_LOG:0]   count,
    output logic [DEPTH_LOG-1:0] addr_rd,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LATCH,
        SEND
    } state_t;

    localparam logic [31:0]          DEPTH_U   = 32'(DEPTH);
    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);
    localparam logic [DEPTH_LOG:0]   COUNT_MAX = (DEPTH_LOG + 1)'(DEPTH);

    state_t               state_q, state_d;
    logic [DEPTH_LOG-1:0] addr_q, addr_d;
    logic [DEPTH_LOG:0]   remaining_q, remaining_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    logic [31:0]          start_addr_ext;
    logic [31:0]          count_ext;
    logic [DEPTH_LOG-1:0] start_addr_mod;
    logic [DEPTH_LOG:0]   count_clamped;
    logic                 xfer;

    // DEPTH need not be a power of two, so out-of-range addresses fold back explicitly.
    assign start_addr_ext = 32'(start_addr);
    assign count_ext      = 32'(count);
    assign start_addr_mod = DEPTH_LOG'(start_addr_ext % DEPTH_U);
    assign count_clamped  = (count_ext > DEPTH_U) ? COUNT_MAX : count;
    assign xfer           = valid_q && m_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (count != '0)) begin
                    addr_d      = start_addr_mod;
                    remaining_d = count_clamped;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                state_d = LATCH;
            end
            LATCH: begin
                data_d  = data_in;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    if (remaining_q > 1) begin
                        remaining_d = remaining_q - 1'b1;
                        addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                        state_d     = ADDR;
                    end else begin
                        remaining_d = '0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign addr_rd = addr_q;
    assign m_data  = data_q;
    assign m_valid = valid_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader against a 16-word ROM holding 8'hA0 + i.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_rom_reader;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int DEPTH_LOG = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic [DEPTH_LOG-1:0] start_addr;
    logic [DEPTH_LOG:0]   count;
    logic [DEPTH_LOG-1:0] addr_rd;
    logic [WIDTH-1:0]     data_in;
    logic [WIDTH-1:0]     m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 busy;
    logic                 done;

    logic [WIDTH-1:0] rom [DEPTH];
    int total;
    int bad;

    typedef struct {
        logic [3:0] sa;
        logic [4:0] cnt;
        int         first;
        int         n;
        int         stall;
    } vec_t;

    vec_t vecs [6];
    vec_t one_vec;

    rom_reader #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .addr_rd    (addr_rd),
        .data_in    (data_in),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'hA0 + 8'(i);
    end

    always @(posedge clk) data_in <= rom[addr_rd];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // t counts falling edges after the edge that accepts start.
    task automatic run_burst(input vec_t v, input bit pre_started, input bit hold, input string tag);
        int         k;
        int         valid_t;
        int         xfer_t;
        int         done_t;
        int         limit;
        logic [7:0] exp_w;
        logic [7:0] last_w;
        k       = 0;
        valid_t = 3;
        xfer_t  = 3 + v.stall;
        done_t  = -1;
        last_w  = '0;
        limit   = 3 * v.n + v.stall + (hold ? 1 : 2);
        if (!pre_started) begin
            @(negedge clk);
            start      = 1'b1;
            start_addr = v.sa;
            count      = v.cnt;
            m_ready    = 1'b0;
        end
        for (int t = 1; t <= limit; t++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            chk({tag, ":done"}, done, (t == done_t));
            chk({tag, ":busy"}, busy, (done_t < 0) || (t < done_t));
            if (k < v.n) begin
                exp_w = 8'hA0 + 8'((v.first + k) % 16);
                chk({tag, ":valid"}, m_valid, (t >= valid_t));
                if (t >= valid_t) chk({tag, ":data"}, m_data, exp_w);
                m_ready = (k > 0) || (t >= xfer_t);
                if (t == xfer_t) begin
                    last_w = exp_w;
                    k++;
                    if (k == v.n) done_t = t + 1;
                    else begin
                        valid_t = t + 3;
                        xfer_t  = t + 3;
                    end
                end
            end else begin
                chk({tag, ":valid_after"}, m_valid, 1'b0);
            end
        end
        if (!hold) chk({tag, ":data_hold"}, m_data, last_w);
        $display("burst %s: start_addr=%0d count=%0d words=%0d stall=%0d", tag, v.sa, v.cnt, k, v.stall);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        m_ready    = 1'b0;

        vecs[0] = '{4'd3,  5'd4,  3,  4,  0};
        vecs[1] = '{4'd14, 5'd4,  14, 4,  0};
        vecs[2] = '{4'd5,  5'd2,  5,  2,  5};
        vecs[3] = '{4'd0,  5'd20, 0,  16, 0};
        vecs[4] = '{4'd9,  5'd16, 9,  16, 0};
        vecs[5] = '{4'd15, 5'd1,  15, 1,  2};

        #2;
        chk("rst:addr_rd", addr_rd, 0);
        chk("rst:m_data", m_data, 0);
        chk("rst:m_valid", m_valid, 0);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        repeat (2) @(negedge clk);
        chk("rst_held:busy", busy, 0);

        // First start lands on the very first rising edge after release.
        reset_n    = 1'b1;
        start      = 1'b1;
        start_addr = vecs[0].sa;
        count      = vecs[0].cnt;
        run_burst(vecs[0], 1'b1, 1'b0, "v0");
        for (int i = 1; i < 6; i++) run_burst(vecs[i], 1'b0, 1'b0, $sformatf("v%0d", i));

        // count == 0 is ignored and addr_rd keeps the last address.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 4'd2;
        count      = '0;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            chk("cnt0:busy", busy, 0);
            chk("cnt0:valid", m_valid, 0);
            chk("cnt0:done", done, 0);
        end
        chk("cnt0:addr_hold", addr_rd, 15);
        start = 1'b0;
        $display("burst cnt0: start_addr=2 count=0 ignored");

        // start held through a burst: accepted again only on the done cycle.
        one_vec = '{4'd0, 5'd2, 0, 2, 0};
        run_burst(one_vec, 1'b0, 1'b1, "b2b_a");
        run_burst(one_vec, 1'b1, 1'b0, "b2b_b");

        // Asynchronous reset while word 2 of a 4-word burst waits in SEND.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 4'd3;
        count      = 5'd4;
        m_ready    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid:valid", m_valid, 1);
        chk("mid:data", m_data, 8'hA4);
        chk("mid:busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async:addr_rd", addr_rd, 0);
        chk("async:m_data", m_data, 0);
        chk("async:m_valid", m_valid, 0);
        chk("async:busy", busy, 0);
        chk("async:done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            chk("post_rst:done", done, 0);
            chk("post_rst:busy", busy, 0);
            chk("post_rst:valid", m_valid, 0);
        end
        $display("burst abort: reset during word 2, no done");
        one_vec = '{4'd0, 5'd1, 0, 1, 0};
        run_burst(one_vec, 1'b0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
